// File: rtl/dkong3_snd_pkg.sv
// Shared constants and types for the 2A03 sound-command mailbox.
package dkong3_snd_pkg;

    localparam logic [15:0] SND_CMD_ADDR  = 16'h4016;
    localparam logic [15:0] SND_STAT_ADDR = 16'h4017;

    localparam int unsigned STAT_NOTEMPTY = 7;
    localparam int unsigned STAT_OVF      = 0;

    typedef enum logic [0:0] {
        StIdle,
        StPulse
    } nmi_state_e;

endpackage

// File: rtl/dkong3_snd_chan.sv
// One sub-CPU channel: $4016/$4017 decode, command store, overflow flag and NMI pulse FSM.
// Command store is a FIFO when DKONG3_SNDCMD_FIFO_EN is defined, otherwise a single latch.
module dkong3_snd_chan
    import dkong3_snd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned NMI_WIDTH  = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_ce_i,
    input  logic        wr_i,
    input  logic [7:0]  wr_data_i,
    input  logic        vb_rise_i,
    input  logic        nmi_en_i,
    input  logic [15:0] addr_i,
    input  logic        rnw_i,
    output logic [7:0]  dbi_o,
    output logic        sel_o,
    output logic        nmi_n_o
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (NMI_WIDTH < 1 || NMI_WIDTH > 255) begin : g_bad_width
        $error("NMI_WIDTH must be in 1..255");
    end

    logic       is_cmd, is_stat, pop_req, stat_rd;
    logic       not_empty, pop, ovf_set;
    logic [7:0] cmd_data;
    logic       ovf_q, ovf_d;

    assign is_cmd  = rnw_i && (addr_i == SND_CMD_ADDR);
    assign is_stat = rnw_i && (addr_i == SND_STAT_ADDR);
    assign sel_o   = is_cmd || is_stat;
    assign pop_req = cpu_ce_i && is_cmd;
    assign stat_rd = cpu_ce_i && is_stat;

`ifdef DKONG3_SNDCMD_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FullCnt = (AW + 1)'(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    hold_q, hold_d;
    logic          full, push;

    assign not_empty = (count_q != '0);
    assign full      = (count_q == FullCnt);
    assign pop       = pop_req && not_empty;
    // A pop in the same clock frees a slot, so a push into a full FIFO is still accepted.
    assign push      = wr_i && (!full || pop);
    assign ovf_set   = wr_i && full && !pop;
    assign cmd_data  = not_empty ? mem_q[rd_ptr_q] : hold_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            hold_d   = mem_q[rd_ptr_q];
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end
`else
    logic [7:0] latch_q, latch_d;
    logic       full_q, full_d;

    // Reads never clear the latch; only the notEmpty flag is consumed.
    assign not_empty = full_q;
    assign pop       = pop_req;
    assign ovf_set   = wr_i && full_q;
    assign cmd_data  = latch_q;

    always_comb begin
        latch_d = latch_q;
        full_d  = full_q;
        if (wr_i) begin
            latch_d = wr_data_i;
            full_d  = 1'b1;
        end else if (pop) begin
            full_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            latch_q <= '0;
            full_q  <= 1'b0;
        end else begin
            latch_q <= latch_d;
            full_q  <= full_d;
        end
    end
`endif

    // Set wins over a same-clock status read.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (stat_rd) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        dbi_o = '0;
        if (is_cmd) begin
            dbi_o = cmd_data;
        end else if (is_stat) begin
            dbi_o[STAT_NOTEMPTY] = not_empty;
            dbi_o[STAT_OVF]      = ovf_q;
        end
    end

    localparam logic [7:0] NmiLoad = 8'(NMI_WIDTH);

    nmi_state_e state_q, state_d;
    logic [7:0] nmi_cnt_q, nmi_cnt_d;

    always_comb begin
        state_d   = state_q;
        nmi_cnt_d = nmi_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (vb_rise_i && nmi_en_i) begin
                    state_d   = StPulse;
                    nmi_cnt_d = NmiLoad;
                end
            end
            StPulse: begin
                if (!nmi_en_i) begin
                    state_d   = StIdle;
                    nmi_cnt_d = '0;
                end else if (cpu_ce_i) begin
                    nmi_cnt_d = nmi_cnt_q - 1'b1;
                    if (nmi_cnt_q == 8'd1) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            nmi_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            nmi_cnt_q <= nmi_cnt_d;
        end
    end

    assign nmi_n_o = (state_q != StPulse);

endmodule

// File: rtl/dkong3_snd_cmd.sv
// Sound-command mailbox and vblank NMI for the two 2A03 sub CPUs.
// Define DKONG3_SNDCMD_FIFO_EN for per-channel FIFOs; default build uses single latches.
module dkong3_snd_cmd
    import dkong3_snd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned NMI_WIDTH  = 8
) (
    input  logic        I_SUBCLK,
    input  logic        I_SUB_RESET,
    input  logic        I_CPU_CE,
    input  logic        I_MAIN_WR,
    input  logic        I_MAIN_SEL,
    input  logic [7:0]  I_MAIN_DB,
    input  logic        I_VBLANK,
    input  logic [1:0]  I_NMI_EN,
    input  logic [15:0] I_SUB1_ADDR,
    input  logic        I_SUB1_RNW,
    input  logic [15:0] I_SUB2_ADDR,
    input  logic        I_SUB2_RNW,
    output logic [7:0]  O_SUB1_DBI,
    output logic        O_SUB1_SEL,
    output logic        O_SUB1_NMIn,
    output logic [7:0]  O_SUB2_DBI,
    output logic        O_SUB2_SEL,
    output logic        O_SUB2_NMIn
);

    logic vb_q, arm_q, vb_rise;
    logic wr1, wr2;

    // arm_q masks the first clock after reset so a vblank already high is not seen as a rise.
    always_ff @(posedge I_SUBCLK) begin
        if (I_SUB_RESET) begin
            vb_q  <= 1'b0;
            arm_q <= 1'b0;
        end else begin
            vb_q  <= I_VBLANK;
            arm_q <= 1'b1;
        end
    end

    assign vb_rise = I_VBLANK && !vb_q && arm_q;
    assign wr1     = I_MAIN_WR && !I_MAIN_SEL;
    assign wr2     = I_MAIN_WR && I_MAIN_SEL;

    dkong3_snd_chan #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .NMI_WIDTH  (NMI_WIDTH)
    ) u_chan1 (
        .clk_i     (I_SUBCLK),
        .rst_i     (I_SUB_RESET),
        .cpu_ce_i  (I_CPU_CE),
        .wr_i      (wr1),
        .wr_data_i (I_MAIN_DB),
        .vb_rise_i (vb_rise),
        .nmi_en_i  (I_NMI_EN[0]),
        .addr_i    (I_SUB1_ADDR),
        .rnw_i     (I_SUB1_RNW),
        .dbi_o     (O_SUB1_DBI),
        .sel_o     (O_SUB1_SEL),
        .nmi_n_o   (O_SUB1_NMIn)
    );

    dkong3_snd_chan #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .NMI_WIDTH  (NMI_WIDTH)
    ) u_chan2 (
        .clk_i     (I_SUBCLK),
        .rst_i     (I_SUB_RESET),
        .cpu_ce_i  (I_CPU_CE),
        .wr_i      (wr2),
        .wr_data_i (I_MAIN_DB),
        .vb_rise_i (vb_rise),
        .nmi_en_i  (I_NMI_EN[1]),
        .addr_i    (I_SUB2_ADDR),
        .rnw_i     (I_SUB2_RNW),
        .dbi_o     (O_SUB2_DBI),
        .sel_o     (O_SUB2_SEL),
        .nmi_n_o   (O_SUB2_NMIn)
    );

endmodule

// File: tb/tb_dkong3_snd_cmd.sv
// Directed self-checking bench for dkong3_snd_cmd (latch or FIFO build).
module tb_dkong3_snd_cmd;

    logic        clk = 1'b0;
    logic        rst, ce, wr, main_sel, vblank;
    logic [7:0]  main_db;
    logic [1:0]  nmi_en;
    logic [15:0] a1, a2;
    logic        rnw1, rnw2;
    logic [7:0]  dbi1, dbi2;
    logic        sel1, sel2, nmi1, nmi2;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    dkong3_snd_cmd #(
        .FIFO_DEPTH (4),
        .NMI_WIDTH  (8)
    ) dut (
        .I_SUBCLK    (clk),
        .I_SUB_RESET (rst),
        .I_CPU_CE    (ce),
        .I_MAIN_WR   (wr),
        .I_MAIN_SEL  (main_sel),
        .I_MAIN_DB   (main_db),
        .I_VBLANK    (vblank),
        .I_NMI_EN    (nmi_en),
        .I_SUB1_ADDR (a1),
        .I_SUB1_RNW  (rnw1),
        .I_SUB2_ADDR (a2),
        .I_SUB2_RNW  (rnw2),
        .O_SUB1_DBI  (dbi1),
        .O_SUB1_SEL  (sel1),
        .O_SUB1_NMIn (nmi1),
        .O_SUB2_DBI  (dbi2),
        .O_SUB2_SEL  (sel2),
        .O_SUB2_NMIn (nmi2)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mwrite(input logic s, input logic [7:0] d);
        wr = 1'b1;
        main_sel = s;
        main_db = d;
        tick();
        wr = 1'b0;
    endtask

    // Drive one CPU read cycle; data is sampled before the edge that may pop.
    task automatic rd_chk(input string tag, input int ch, input logic [15:0] adr,
                          input logic with_ce, input logic [7:0] exp);
        logic [7:0] d;
        if (ch == 1) a1 = adr;
        else a2 = adr;
        ce = with_ce;
        #1;
        d = (ch == 1) ? dbi1 : dbi2;
        check_eq(tag, {8'h00, d}, {8'h00, exp});
        tick();
        ce = 1'b0;
        a1 = 16'h0000;
        a2 = 16'h0000;
    endtask

    initial begin
        int low1, low2;
        rst = 1'b1; ce = 1'b0; wr = 1'b0; main_sel = 1'b0; main_db = 8'h00;
        vblank = 1'b0; nmi_en = 2'b00; a1 = 16'h0000; a2 = 16'h0000;
        rnw1 = 1'b1; rnw2 = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        check_eq("rst_nmi1", {15'd0, nmi1}, 16'd1);
        check_eq("rst_nmi2", {15'd0, nmi2}, 16'd1);
        check_eq("rst_sel1", {15'd0, sel1}, 16'd0);
        check_eq("rst_dbi1", {8'd0, dbi1}, 16'h0000);
        rd_chk("rst_stat1", 1, 16'h4017, 1'b0, 8'h00);
        rd_chk("rst_cmd1", 1, 16'h4016, 1'b0, 8'h00);

`ifdef DKONG3_SNDCMD_FIFO_EN
        mwrite(1'b0, 8'h11);
        rd_chk("pp_stat1", 1, 16'h4017, 1'b0, 8'h80);
        mwrite(1'b0, 8'h22);
        rd_chk("pp_pop1", 1, 16'h4016, 1'b1, 8'h11);
        rd_chk("pp_pop2", 1, 16'h4016, 1'b1, 8'h22);
        rd_chk("pp_hold", 1, 16'h4016, 1'b1, 8'h22);
        rd_chk("pp_stat2", 1, 16'h4017, 1'b0, 8'h00);

        for (int i = 1; i <= 5; i++) mwrite(1'b0, 8'(i));
        rd_chk("ovf_stat", 1, 16'h4017, 1'b1, 8'h81);
        rd_chk("ovf_clr", 1, 16'h4017, 1'b0, 8'h80);
        for (int i = 1; i <= 4; i++) rd_chk($sformatf("ovf_pop%0d", i), 1, 16'h4016, 1'b1, 8'(i));
        rd_chk("ovf_empty", 1, 16'h4017, 1'b0, 8'h00);

        for (int i = 0; i < 4; i++) mwrite(1'b0, 8'hA1 + 8'(i));
        wr = 1'b1; main_sel = 1'b0; main_db = 8'hAA;
        rd_chk("sim_head", 1, 16'h4016, 1'b1, 8'hA1);
        wr = 1'b0;
        rd_chk("sim_stat", 1, 16'h4017, 1'b0, 8'h80);
        rd_chk("sim_pop2", 1, 16'h4016, 1'b1, 8'hA2);
        rd_chk("sim_pop3", 1, 16'h4016, 1'b1, 8'hA3);
        rd_chk("sim_pop4", 1, 16'h4016, 1'b1, 8'hA4);
        rd_chk("sim_popaa", 1, 16'h4016, 1'b1, 8'hAA);
        rd_chk("sim_empty", 1, 16'h4017, 1'b0, 8'h00);
`else
        mwrite(1'b0, 8'h11);
        rd_chk("lt_stat1", 1, 16'h4017, 1'b0, 8'h80);
        rd_chk("lt_rd1", 1, 16'h4016, 1'b1, 8'h11);
        rd_chk("lt_stat2", 1, 16'h4017, 1'b0, 8'h00);
        rd_chk("lt_rd2", 1, 16'h4016, 1'b0, 8'h11);
        mwrite(1'b0, 8'h22);
        mwrite(1'b0, 8'h33);
        rd_chk("lt_ovf", 1, 16'h4017, 1'b1, 8'h81);
        rd_chk("lt_ovfclr", 1, 16'h4017, 1'b0, 8'h80);
        rd_chk("lt_rd3", 1, 16'h4016, 1'b1, 8'h33);
        rd_chk("lt_stat3", 1, 16'h4017, 1'b0, 8'h00);
`endif

        mwrite(1'b1, 8'h55);
        rd_chk("iso_cmd2", 2, 16'h4016, 1'b0, 8'h55);
        rd_chk("iso_stat2", 2, 16'h4017, 1'b0, 8'h80);
        rd_chk("iso_stat1", 1, 16'h4017, 1'b0, 8'h00);
        a1 = 16'h8000;
        #1;
        check_eq("iso_sel1", {15'd0, sel1}, 16'd0);
        check_eq("iso_dbi1", {8'd0, dbi1}, 16'h0000);
        a1 = 16'h4016;
        rnw1 = 1'b0;
        #1;
        check_eq("iso_wrsel1", {15'd0, sel1}, 16'd0);
        rnw1 = 1'b1;
        a1 = 16'h0000;

        // NMI pulse: CE every third clock, re-rise mid-pulse must not retrigger.
        nmi_en = 2'b11;
        tick();
        tick();
        low1 = 0;
        low2 = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 0) vblank = 1'b1;
            if (i == 6) vblank = 1'b0;
            if (i == 9) vblank = 1'b1;
            ce = (i % 3 == 0);
            if (i == 1) begin
                check_eq("nmi_fall1", {15'd0, nmi1}, 16'd0);
                check_eq("nmi_fall2", {15'd0, nmi2}, 16'd0);
            end
            if (!nmi1 && ce) low1++;
            if (!nmi2 && ce) low2++;
            tick();
        end
        ce = 1'b0;
        check_eq("nmi_len1", 16'(low1), 16'd8);
        check_eq("nmi_len2", 16'(low2), 16'd8);
        check_eq("nmi_end1", {15'd0, nmi1}, 16'd1);
        check_eq("nmi_end2", {15'd0, nmi2}, 16'd1);

        vblank = 1'b0;
        tick();
        tick();
        vblank = 1'b1;
        tick();
        check_eq("en_low1", {15'd0, nmi1}, 16'd0);
        nmi_en = 2'b10;
        tick();
        check_eq("en_rel1", {15'd0, nmi1}, 16'd1);
        check_eq("en_hold2", {15'd0, nmi2}, 16'd0);

        nmi_en = 2'b11;
        mwrite(1'b0, 8'h66);
        mwrite(1'b1, 8'h77);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rr_nmi1", {15'd0, nmi1}, 16'd1);
        check_eq("rr_nmi2", {15'd0, nmi2}, 16'd1);
        rd_chk("rr_stat1", 1, 16'h4017, 1'b0, 8'h00);
        rd_chk("rr_stat2", 2, 16'h4017, 1'b0, 8'h00);
        rd_chk("rr_cmd1", 1, 16'h4016, 1'b0, 8'h00);
        low1 = 0;
        low2 = 0;
        for (int i = 0; i < 12; i++) begin
            ce = (i % 3 == 0);
            if (!nmi1) low1++;
            if (!nmi2) low2++;
            tick();
        end
        ce = 1'b0;
        check_eq("rr_nonmi1", 16'(low1), 16'd0);
        check_eq("rr_nonmi2", 16'(low2), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
